// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Turns the validated PS/2 byte stream (scan-code set 2) into single key
//   events. E0/F0/E1 prefixes are folded into ext/break flags. Modifier
//   and caps-lock state are tracked, and events are queued in a
//   first-word-fall-through FIFO.
//
//   Optional macro: PS2_ASCII_EN adds ASCII translation to each event.
//   Without it, o_evt_ascii is tied to 0.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_byte, i_byte_valid  received byte plus one-cycle strobe
//   o_evt_valid           FIFO head valid
//   i_evt_ready           consumer accepts the head
//   o_evt_code/ext/break  head scan code, E0 flag, release flag
//   o_evt_ascii           head ASCII (0 unless PS2_ASCII_EN)
//   o_shift/ctrl/alt      modifier held state
//   o_caps                caps-lock toggle state
//   o_overflow            sticky event-dropped flag
//   i_clr_ovf             clears o_overflow
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH     = 8,
    parameter int PREFIX_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    output logic       o_evt_valid,
    input  logic       i_evt_ready,
    output logic [7:0] o_evt_code,
    output logic       o_evt_ext,
    output logic       o_evt_break,
    output logic [7:0] o_evt_ascii,
    output logic       o_shift,
    output logic       o_ctrl,
    output logic       o_alt,
    output logic       o_caps,
    output logic       o_overflow,
    input  logic       i_clr_ovf
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TO_W = $clog2(PREFIX_TIMEOUT + 1);
`ifdef PS2_ASCII_EN
    localparam int EW = 18;
`else
    localparam int EW = 10;
`endif

    typedef enum logic [2:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP_E1} state_t;

    state_t          state, state_nxt;
    logic [2:0]      skip_cnt, skip_nxt;
    logic [TO_W-1:0] to_cnt;
    logic            timeout;
    logic            push;
    logic [7:0]      ev_code;
    logic            ev_ext, ev_brk;
    logic            lshift, rshift, caps_held;
    logic [EW-1:0]   wr_data;

    // A pending prefix is abandoned once PREFIX_TIMEOUT cycles pass without a byte.
    assign timeout = (state != IDLE) && !i_byte_valid &&
                     (to_cnt == TO_W'(PREFIX_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            skip_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
            if (i_byte_valid || state == IDLE || timeout)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        push      = 1'b0;
        ev_code   = i_byte;
        ev_ext    = 1'b0;
        ev_brk    = 1'b0;
        if (i_byte_valid) begin
            case (state)
                IDLE: begin
                    case (i_byte)
                        8'hE0: state_nxt = GOT_E0;
                        8'hF0: state_nxt = GOT_F0;
                        8'hE1: begin
                            state_nxt = SKIP_E1;
                            skip_nxt  = 3'd7;
                        end
                        // Controller responses / error codes: not key events.
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                        default: push = 1'b1;
                    endcase
                end
                GOT_E0: begin
                    if (i_byte == 8'hF0) begin
                        state_nxt = GOT_E0F0;
                    end else if (i_byte != 8'hE0) begin
                        state_nxt = IDLE;
                        // E0 12 is the keyboard's fake shift; drop it.
                        push   = (i_byte != 8'h12);
                        ev_ext = 1'b1;
                    end
                end
                GOT_F0: begin
                    state_nxt = IDLE;
                    push      = 1'b1;
                    ev_brk    = 1'b1;
                end
                GOT_E0F0: begin
                    state_nxt = IDLE;
                    push      = (i_byte != 8'h12);
                    ev_ext    = 1'b1;
                    ev_brk    = 1'b1;
                end
                SKIP_E1: begin
                    skip_nxt = skip_cnt - 3'd1;
                    // Pause/Break: the whole 8-byte sequence becomes one event.
                    if (skip_cnt == 3'd1) begin
                        state_nxt = IDLE;
                        push      = 1'b1;
                        ev_code   = 8'hE1;
                        ev_ext    = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = IDLE;
        end
    end

    // Modifiers follow every decoded event, even one the FIFO drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            o_ctrl    <= 1'b0;
            o_alt     <= 1'b0;
            o_caps    <= 1'b0;
            caps_held <= 1'b0;
        end else if (push) begin
            if (ev_code == 8'h12 && !ev_ext) lshift <= !ev_brk;
            if (ev_code == 8'h59 && !ev_ext) rshift <= !ev_brk;
            if (ev_code == 8'h14) o_ctrl <= !ev_brk;
            if (ev_code == 8'h11) o_alt  <= !ev_brk;
            if (ev_code == 8'h58 && !ev_ext) begin
                // caps_held blocks typematic repeats from re-toggling.
                if (ev_brk) begin
                    caps_held <= 1'b0;
                end else begin
                    if (!caps_held) o_caps <= !o_caps;
                    caps_held <= 1'b1;
                end
            end
        end
    end

    assign o_shift = lshift | rshift;

`ifdef PS2_ASCII_EN
    function automatic logic [7:0] letter_of(input logic [7:0] c);
        case (c)
            8'h1C: return "a";  8'h32: return "b";  8'h21: return "c";
            8'h23: return "d";  8'h24: return "e";  8'h2B: return "f";
            8'h34: return "g";  8'h33: return "h";  8'h43: return "i";
            8'h3B: return "j";  8'h42: return "k";  8'h4B: return "l";
            8'h3A: return "m";  8'h31: return "n";  8'h44: return "o";
            8'h4D: return "p";  8'h15: return "q";  8'h2D: return "r";
            8'h1B: return "s";  8'h2C: return "t";  8'h3C: return "u";
            8'h2A: return "v";  8'h1D: return "w";  8'h22: return "x";
            8'h35: return "y";  8'h1A: return "z";
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ascii_of(input logic [7:0] c, input logic upper);
        logic [7:0] l;
        l = letter_of(c);
        if (l != 8'h00) return upper ? (l - 8'h20) : l;
        case (c)
            8'h16: return "1";  8'h1E: return "2";  8'h26: return "3";
            8'h25: return "4";  8'h2E: return "5";  8'h36: return "6";
            8'h3D: return "7";  8'h3E: return "8";  8'h46: return "9";
            8'h45: return "0";
            8'h29: return 8'h20;
            8'h5A: return 8'h0D;
            8'h66: return 8'h08;
            8'h0D: return 8'h09;
            default: return 8'h00;
        endcase
    endfunction

    // Uses modifier state from before this byte's own update.
    assign wr_data = {((!ev_ext && !ev_brk) ? ascii_of(ev_code, o_shift ^ o_caps) : 8'h00),
                      ev_brk, ev_ext, ev_code};
`else
    assign wr_data = {ev_brk, ev_ext, ev_code};
`endif

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, wr_en;
    logic [EW-1:0] hold_q, head;

    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    assign o_evt_valid = (count != '0);
    assign pop         = o_evt_valid && i_evt_ready;
    assign wr_en       = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_q     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)      count <= count + 1'b1;
            else if (!wr_en && pop) count <= count - 1'b1;
            // Remember the last shown head so outputs hold when the FIFO empties.
            if (o_evt_valid) hold_q <= mem[rd_ptr];
            if (push && full && !pop) o_overflow <= 1'b1;
            else if (i_clr_ovf)       o_overflow <= 1'b0;
        end
    end

    assign head        = o_evt_valid ? mem[rd_ptr] : hold_q;
    assign o_evt_code  = head[7:0];
    assign o_evt_ext   = head[8];
    assign o_evt_break = head[9];
`ifdef PS2_ASCII_EN
    assign o_evt_ascii = head[17:10];
`else
    assign o_evt_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder
//   Directed bench for ps2_scancode_decoder (FIFO_DEPTH=8, short timeout).
//   Expected ASCII values follow PS2_ASCII_EN; without it they are 0.
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 8;
    localparam int TMO   = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       i_byte_valid = 1'b0;
    logic       i_evt_ready = 1'b0;
    logic       i_clr_ovf = 1'b0;
    logic       o_evt_valid, o_evt_ext, o_evt_break;
    logic [7:0] o_evt_code, o_evt_ascii;
    logic       o_shift, o_ctrl, o_alt, o_caps, o_overflow;

    int total = 0;
    int bad   = 0;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .PREFIX_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_byte(i_byte), .i_byte_valid(i_byte_valid),
        .o_evt_valid(o_evt_valid), .i_evt_ready(i_evt_ready),
        .o_evt_code(o_evt_code), .o_evt_ext(o_evt_ext), .o_evt_break(o_evt_break),
        .o_evt_ascii(o_evt_ascii),
        .o_shift(o_shift), .o_ctrl(o_ctrl), .o_alt(o_alt), .o_caps(o_caps),
        .o_overflow(o_overflow), .i_clr_ovf(i_clr_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xa(input logic [7:0] a);
`ifdef PS2_ASCII_EN
        return a;
`else
        return 8'h00;
`endif
    endfunction

    // All driving happens at negedge; send returns one negedge later.
    task automatic send(input logic [7:0] b);
        i_byte       = b;
        i_byte_valid = 1'b1;
        @(negedge clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Waits (bounded) for the head, captures it and pops it.
    task automatic get_evt(output logic [7:0] c, output logic e, output logic b,
                           output logic [7:0] a);
        int n;
        n = 0;
        while (!o_evt_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (o_evt_valid !== 1'b1) begin
            bad++;
            $display("FAIL get_evt_wait: valid=%b required=1", o_evt_valid);
        end
        c = o_evt_code; e = o_evt_ext; b = o_evt_break; a = o_evt_ascii;
        i_evt_ready = 1'b1;
        @(negedge clk);
        i_evt_ready = 1'b0;
    endtask

    task automatic test_reset;
        total++;
        if ({o_evt_valid, o_evt_code, o_evt_ext, o_evt_break, o_evt_ascii,
             o_shift, o_ctrl, o_alt, o_caps, o_overflow} !== 25'd0) begin
            bad++;
            $display("FAIL reset_outputs: got code=%h valid=%b ovf=%b required all 0",
                     o_evt_code, o_evt_valid, o_overflow);
        end
    endtask

    task automatic test_make;
        i_evt_ready = 1'b1;
        total++;
        if (o_evt_valid !== 1'b0) begin
            bad++; $display("FAIL make_pre_valid: got=%b required=0", o_evt_valid);
        end
        send(8'h1C);
        total++;
        if ({o_evt_valid, o_evt_code, o_evt_ext, o_evt_break} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL make_event: valid=%b code=%h ext=%b brk=%b required 1/1c/0/0",
                     o_evt_valid, o_evt_code, o_evt_ext, o_evt_break);
        end
        total++;
        if (o_evt_ascii !== xa(8'h61)) begin
            bad++; $display("FAIL make_ascii: got=%h required=%h", o_evt_ascii, xa(8'h61));
        end
        @(negedge clk);
        i_evt_ready = 1'b0;
        total++;
        if ({o_evt_valid, o_evt_code} !== {1'b0, 8'h1C}) begin
            bad++;
            $display("FAIL make_popped_hold: valid=%b code=%h required 0/1c",
                     o_evt_valid, o_evt_code);
        end
    endtask

    task automatic test_prefix;
        logic [7:0] c, a; logic e, b;
        send(8'hF0); send(8'h1C);
        get_evt(c, e, b, a);
        total++;
        if ({c, e, b, a} !== {8'h1C, 1'b0, 1'b1, 8'h00}) begin
            bad++; $display("FAIL f0_break: got %h/%b/%b/%h required 1c/0/1/00", c, e, b, a);
        end
        send(8'hE0); send(8'h75);
        get_evt(c, e, b, a);
        total++;
        if ({c, e, b} !== {8'h75, 1'b1, 1'b0}) begin
            bad++; $display("FAIL e0_make: got %h/%b/%b required 75/1/0", c, e, b);
        end
        send(8'hE0); send(8'hF0); send(8'h75);
        get_evt(c, e, b, a);
        total++;
        if ({c, e, b, a} !== {8'h75, 1'b1, 1'b1, 8'h00}) begin
            bad++; $display("FAIL e0f0_break: got %h/%b/%b/%h required 75/1/1/00", c, e, b, a);
        end
        send(8'hE0); send(8'h12);
        send(8'hE0); send(8'hF0); send(8'h12);
        send(8'hFA); send(8'hAA);
        idle(3);
        total++;
        if ({o_evt_valid, o_shift} !== 2'b00) begin
            bad++;
            $display("FAIL fake_shift_discard: valid=%b shift=%b required 0/0",
                     o_evt_valid, o_shift);
        end
    endtask

    task automatic test_shift;
        logic [7:0] c, a; logic e, b;
        send(8'h12);
        total++;
        if (o_shift !== 1'b1) begin
            bad++; $display("FAIL shift_set: got=%b required=1", o_shift);
        end
        send(8'h1C);
        send(8'h16);
        send(8'hF0); send(8'h12);
        total++;
        if (o_shift !== 1'b0) begin
            bad++; $display("FAIL shift_clear: got=%b required=0", o_shift);
        end
        get_evt(c, e, b, a);
        total++;
        if ({c, e, b} !== {8'h12, 1'b0, 1'b0}) begin
            bad++; $display("FAIL shift_evt1: got %h/%b/%b required 12/0/0", c, e, b);
        end
        get_evt(c, e, b, a);
        total++;
        if ({c, a} !== {8'h1C, xa(8'h41)}) begin
            bad++; $display("FAIL shift_upper_a: got %h/%h required 1c/%h", c, a, xa(8'h41));
        end
        get_evt(c, e, b, a);
        total++;
        if ({c, a} !== {8'h16, xa(8'h31)}) begin
            bad++; $display("FAIL shift_digit: got %h/%h required 16/%h", c, a, xa(8'h31));
        end
        get_evt(c, e, b, a);
        total++;
        if ({c, e, b, o_evt_valid} !== {8'h12, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL shift_evt4: got %h/%b/%b valid=%b required 12/0/1 valid=0",
                     c, e, b, o_evt_valid);
        end
    endtask

    task automatic test_modifiers;
        logic [7:0] c, a; logic e, b;
        send(8'h59);
        send(8'hE0); send(8'h14);
        send(8'h11);
        total++;
        if ({o_shift, o_ctrl, o_alt} !== 3'b111) begin
            bad++; $display("FAIL mods_set: got shift/ctrl/alt=%b%b%b required 111",
                            o_shift, o_ctrl, o_alt);
        end
        send(8'hF0); send(8'h59);
        send(8'hF0); send(8'h14);
        send(8'hE0); send(8'hF0); send(8'h11);
        total++;
        if ({o_shift, o_ctrl, o_alt} !== 3'b000) begin
            bad++; $display("FAIL mods_clear: got shift/ctrl/alt=%b%b%b required 000",
                            o_shift, o_ctrl, o_alt);
        end
        for (int i = 0; i < 6; i++) get_evt(c, e, b, a);
    endtask

    task automatic test_caps;
        logic [7:0] c, a; logic e, b;
        send(8'h58);
        total++;
        if (o_caps !== 1'b1) begin
            bad++; $display("FAIL caps_first: got=%b required=1", o_caps);
        end
        send(8'h58);
        total++;
        if (o_caps !== 1'b1) begin
            bad++; $display("FAIL caps_repeat: got=%b required=1", o_caps);
        end
        send(8'hF0); send(8'h58);
        send(8'h1C);
        send(8'h58);
        total++;
        if (o_caps !== 1'b0) begin
            bad++; $display("FAIL caps_second: got=%b required=0", o_caps);
        end
        send(8'hF0); send(8'h58);
        for (int i = 0; i < 3; i++) get_evt(c, e, b, a);
        get_evt(c, e, b, a);
        total++;
        if ({c, a} !== {8'h1C, xa(8'h41)}) begin
            bad++; $display("FAIL caps_upper_a: got %h/%h required 1c/%h", c, a, xa(8'h41));
        end
        for (int i = 0; i < 2; i++) get_evt(c, e, b, a);
    endtask

    task automatic test_overflow;
        logic [7:0] c, a; logic e, b;
        for (int i = 1; i <= DEPTH; i++) send(8'(i));
        total++;
        if ({o_evt_valid, o_overflow} !== 2'b10) begin
            bad++; $display("FAIL ovf_full_no_drop: valid=%b ovf=%b required 1/0",
                            o_evt_valid, o_overflow);
        end
        send(8'h09);
        total++;
        if (o_overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_set: got=%b required=1", o_overflow);
        end
        i_clr_ovf = 1'b1;
        send(8'h0A);
        i_clr_ovf = 1'b0;
        total++;
        if (o_overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_set_wins: got=%b required=1", o_overflow);
        end
        i_clr_ovf = 1'b1;
        @(negedge clk);
        i_clr_ovf = 1'b0;
        total++;
        if (o_overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_clear: got=%b required=0", o_overflow);
        end
        // Full FIFO with simultaneous push and pop: 01 leaves, 0B enters.
        i_evt_ready = 1'b1;
        send(8'h0B);
        i_evt_ready = 1'b0;
        total++;
        if (o_overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_push_pop: got=%b required=0", o_overflow);
        end
        for (int i = 2; i <= DEPTH + 1; i++) begin
            get_evt(c, e, b, a);
            total++;
            if (c !== ((i <= DEPTH) ? 8'(i) : 8'h0B)) begin
                bad++; $display("FAIL ovf_drain_%0d: got=%h required=%h", i, c,
                                (i <= DEPTH) ? 8'(i) : 8'h0B);
            end
        end
        total++;
        if (o_evt_valid !== 1'b0) begin
            bad++; $display("FAIL ovf_empty: valid=%b required=0", o_evt_valid);
        end
    endtask

    task automatic test_timeout;
        logic [7:0] c, a; logic e, b;
        send(8'hE0);
        idle(TMO - 3);
        send(8'h75);
        get_evt(c, e, b, a);
        total++;
        if ({c, e} !== {8'h75, 1'b1}) begin
            bad++; $display("FAIL prefix_kept: got %h/%b required 75/1", c, e);
        end
        send(8'hE0);
        idle(TMO + 1);
        send(8'h1C);
        get_evt(c, e, b, a);
        total++;
        if ({c, e, b} !== {8'h1C, 1'b0, 1'b0}) begin
            bad++; $display("FAIL prefix_timeout: got %h/%b/%b required 1c/0/0", c, e, b);
        end
    endtask

    task automatic test_e1;
        logic [7:0] c, a; logic e, b;
        logic [7:0] seq [7];
        seq = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        send(8'hE1);
        for (int i = 0; i < 6; i++) send(seq[i]);
        total++;
        if (o_evt_valid !== 1'b0) begin
            bad++; $display("FAIL e1_skipping: valid=%b required=0", o_evt_valid);
        end
        send(seq[6]);
        get_evt(c, e, b, a);
        total++;
        if ({c, e, b, a} !== {8'hE1, 1'b1, 1'b0, 8'h00}) begin
            bad++; $display("FAIL e1_event: got %h/%b/%b/%h required e1/1/0/00", c, e, b, a);
        end
        idle(2);
        total++;
        if ({o_evt_valid, o_ctrl} !== 2'b00) begin
            bad++; $display("FAIL e1_single: valid=%b ctrl=%b required 0/0",
                            o_evt_valid, o_ctrl);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] c, a; logic e, b;
        send(8'h1C);
        send(8'hE0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({o_evt_valid, o_evt_code} !== 9'd0) begin
            bad++; $display("FAIL reset_mid_empty: valid=%b code=%h required 0/00",
                            o_evt_valid, o_evt_code);
        end
        send(8'h75);
        get_evt(c, e, b, a);
        total++;
        if ({c, e, b} !== {8'h75, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_mid_idle: got %h/%b/%b required 75/0/0", c, e, b);
        end
    endtask

    initial begin
        idle(3);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_make;
        test_prefix;
        test_shift;
        test_modifiers;
        test_caps;
        test_overflow;
        test_timeout;
        test_e1;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
